takvim_denetleyici: RTL

Sequential calendar controller that owns the current time-of-calendar state (year, month, day, hour, weekday) and advances it one hour per external tick. It also runs a multi-hour fast-forward with a start/busy/done handshake and accepts validated direct loads. Its outputs feed the calendar display and conversion datapath as a registered, always-consistent time base.

---
 rtl/takvim_pkg.sv | 30 +++
 rtl/takvim_adim.sv | 67 ++++++
 rtl/takvim_denetleyici.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/takvim_pkg.sv
// Shared constants, state type and calendar helpers for the calendar controller.
package takvim_pkg;

  localparam int SAAT_GUN  = 24;
  localparam int GUN_HAFTA = 7;
  localparam int AY_YIL    = 12;

  typedef enum logic [0:0] {
    BOSTA = 1'b0,
    ILERI = 1'b1
  } durum_e;

  // Year offsets divisible by four are leap years.
  function automatic logic artik_mi(input logic [1:0] yil_lsb);
    artik_mi = (yil_lsb == 2'd0);
  endfunction

  // Days in a month; an out-of-range month yields 0 so no day can be valid in it.
  function automatic logic [4:0] ay_uzunlugu(input logic [3:0] ay, input logic artik);
    logic [4:0] uzunluk;
    case (ay)
      4'd0, 4'd2, 4'd4, 4'd6, 4'd7, 4'd9, 4'd11: uzunluk = 5'd31;
      4'd3, 4'd5, 4'd8, 4'd10:                   uzunluk = 5'd30;
      4'd1:                                      uzunluk = artik ? 5'd29 : 5'd28;
      default:                                   uzunluk = 5'd0;
    endcase
    return uzunluk;
  endfunction

endpackage

// File: rtl/takvim_adim.sv
// Combinational one-hour advance of the calendar fields, shared by the tick
// and fast-forward paths.
module takvim_adim
  import takvim_pkg::*;
#(
  parameter int YIL_W = 5
) (
  input  logic [YIL_W-1:0] yil_i,
  input  logic [3:0]       ay_i,
  input  logic [4:0]       gun_i,
  input  logic [4:0]       saat_i,
  input  logic [2:0]       hg_i,
  output logic [YIL_W-1:0] yil_o,
  output logic [3:0]       ay_o,
  output logic [4:0]       gun_o,
  output logic [4:0]       saat_o,
  output logic [2:0]       hg_o,
  output logic             gun_bitti_o,
  output logic             yil_tasma_o
);

  localparam logic [YIL_W-1:0] YIL_BIR = YIL_W'(1);
  localparam logic [YIL_W-1:0] YIL_MAX = {YIL_W{1'b1}};

  logic [4:0] son_gun_s;

  assign son_gun_s = ay_uzunlugu(ay_i, artik_mi(yil_i[1:0])) - 5'd1;

  // Ripple the carry hour -> day/weekday -> month -> year.
  always_comb begin
    yil_o       = yil_i;
    ay_o        = ay_i;
    gun_o       = gun_i;
    saat_o      = saat_i + 5'd1;
    hg_o        = hg_i;
    gun_bitti_o = 1'b0;
    yil_tasma_o = 1'b0;
    if (saat_i >= 5'(SAAT_GUN - 1)) begin
      saat_o      = 5'd0;
      gun_bitti_o = 1'b1;
      if (hg_i >= 3'(GUN_HAFTA - 1)) begin
        hg_o = 3'd0;
      end else begin
        hg_o = hg_i + 3'd1;
      end
      if (gun_i >= son_gun_s) begin
        gun_o = 5'd0;
        if (ay_i >= 4'(AY_YIL - 1)) begin
          ay_o = 4'd0;
          if (yil_i == YIL_MAX) begin
            yil_o       = '0;
            yil_tasma_o = 1'b1;
          end else begin
            yil_o = yil_i + YIL_BIR;
          end
        end else begin
          ay_o = ay_i + 4'd1;
        end
      end else begin
        gun_o = gun_i + 5'd1;
      end
    end else begin
      saat_o = saat_i + 5'd1;
    end
  end

endmodule

// File: rtl/takvim_denetleyici.sv
// Calendar controller: hourly tick advance, validated direct load and a
// multi-hour fast-forward with start/busy/done handshake.
module takvim_denetleyici
  import takvim_pkg::*;
#(
  parameter int YIL_W        = 5,
  parameter int ILERI_W      = 10,
  parameter int BASLANGIC_HG = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               saat_tick,
  input  logic               yukle,
  input  logic [YIL_W-1:0]   yukle_yil,
  input  logic [3:0]         yukle_ay,
  input  logic [4:0]         yukle_gun,
  input  logic [4:0]         yukle_saat,
  input  logic [2:0]         yukle_hg,
  input  logic               ileri_baslat,
  input  logic [ILERI_W-1:0] ileri_saat,
  output logic [YIL_W-1:0]   yil,
  output logic [3:0]         ay,
  output logic [4:0]         gun,
  output logic [4:0]         saat,
  output logic [2:0]         haftanin_gunu,
  output logic               artik_yil,
  output logic               mesgul,
  output logic               bitti,
  output logic               hata,
  output logic               gun_bitti,
  output logic               yil_tasma
);

  localparam logic [ILERI_W:0] KALAN_BIR = {{ILERI_W{1'b0}}, 1'b1};

  durum_e             durum_q, durum_d;
  logic [YIL_W-1:0]   yil_q, yil_d;
  logic [3:0]         ay_q, ay_d;
  logic [4:0]         gun_q, gun_d;
  logic [4:0]         saat_q, saat_d;
  logic [2:0]         hg_q, hg_d;
  logic [ILERI_W:0]   kalan_q, kalan_d;
  logic               mesgul_q, mesgul_d;
  logic               bitti_q, bitti_d;
  logic               hata_q, hata_d;
  logic               gun_bitti_q, gun_bitti_d;
  logic               yil_tasma_q, yil_tasma_d;

  logic [YIL_W-1:0]   adim_yil_s;
  logic [3:0]         adim_ay_s;
  logic [4:0]         adim_gun_s;
  logic [4:0]         adim_saat_s;
  logic [2:0]         adim_hg_s;
  logic               adim_gun_bitti_s;
  logic               adim_yil_tasma_s;
  logic               adim_al_s;
  logic               yukle_gecerli_s;

  takvim_adim #(
    .YIL_W (YIL_W)
  ) u_adim (
    .yil_i       (yil_q),
    .ay_i        (ay_q),
    .gun_i       (gun_q),
    .saat_i      (saat_q),
    .hg_i        (hg_q),
    .yil_o       (adim_yil_s),
    .ay_o        (adim_ay_s),
    .gun_o       (adim_gun_s),
    .saat_o      (adim_saat_s),
    .hg_o        (adim_hg_s),
    .gun_bitti_o (adim_gun_bitti_s),
    .yil_tasma_o (adim_yil_tasma_s)
  );

  assign yukle_gecerli_s = (yukle_ay <= 4'(AY_YIL - 1))
                         && (yukle_gun < ay_uzunlugu(yukle_ay, artik_mi(yukle_yil[1:0])))
                         && (yukle_saat <= 5'(SAAT_GUN - 1))
                         && (yukle_hg <= 3'(GUN_HAFTA - 1));

  // Next-state: request arbitration in BOSTA, one step per cycle in ILERI.
  always_comb begin
    durum_d     = durum_q;
    yil_d       = yil_q;
    ay_d        = ay_q;
    gun_d       = gun_q;
    saat_d      = saat_q;
    hg_d        = hg_q;
    kalan_d     = kalan_q;
    mesgul_d    = mesgul_q;
    bitti_d     = 1'b0;
    hata_d      = 1'b0;
    gun_bitti_d = 1'b0;
    yil_tasma_d = 1'b0;
    adim_al_s   = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (yukle) begin
          if (yukle_gecerli_s) begin
            yil_d  = yukle_yil;
            ay_d   = yukle_ay;
            gun_d  = yukle_gun;
            saat_d = yukle_saat;
            hg_d   = yukle_hg;
          end else begin
            hata_d = 1'b1;
          end
        end else if (ileri_baslat) begin
          if (ileri_saat == '0) begin
            bitti_d = 1'b1;
          end else begin
            kalan_d  = {1'b0, ileri_saat};
            durum_d  = ILERI;
            mesgul_d = 1'b1;
          end
        end else if (saat_tick) begin
          adim_al_s = 1'b1;
        end else begin
          adim_al_s = 1'b0;
        end
      end
      ILERI: begin
        adim_al_s = 1'b1;
        hata_d    = yukle | ileri_baslat;
        // A concurrent tick cancels this cycle's decrement, extending the run.
        if (saat_tick) begin
          kalan_d = kalan_q;
        end else if (kalan_q == KALAN_BIR) begin
          kalan_d  = '0;
          durum_d  = BOSTA;
          mesgul_d = 1'b0;
          bitti_d  = 1'b1;
        end else begin
          kalan_d = kalan_q - KALAN_BIR;
        end
      end
      default: begin
        durum_d  = BOSTA;
        kalan_d  = '0;
        mesgul_d = 1'b0;
      end
    endcase
    if (adim_al_s) begin
      yil_d       = adim_yil_s;
      ay_d        = adim_ay_s;
      gun_d       = adim_gun_s;
      saat_d      = adim_saat_s;
      hg_d        = adim_hg_s;
      gun_bitti_d = adim_gun_bitti_s;
      yil_tasma_d = adim_yil_tasma_s;
    end else begin
      gun_bitti_d = 1'b0;
      yil_tasma_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q     <= BOSTA;
      yil_q       <= '0;
      ay_q        <= 4'd0;
      gun_q       <= 5'd0;
      saat_q      <= 5'd0;
      hg_q        <= 3'(BASLANGIC_HG);
      kalan_q     <= '0;
      mesgul_q    <= 1'b0;
      bitti_q     <= 1'b0;
      hata_q      <= 1'b0;
      gun_bitti_q <= 1'b0;
      yil_tasma_q <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      yil_q       <= yil_d;
      ay_q        <= ay_d;
      gun_q       <= gun_d;
      saat_q      <= saat_d;
      hg_q        <= hg_d;
      kalan_q     <= kalan_d;
      mesgul_q    <= mesgul_d;
      bitti_q     <= bitti_d;
      hata_q      <= hata_d;
      gun_bitti_q <= gun_bitti_d;
      yil_tasma_q <= yil_tasma_d;
    end
  end

  assign yil           = yil_q;
  assign ay            = ay_q;
  assign gun           = gun_q;
  assign saat          = saat_q;
  assign haftanin_gunu = hg_q;
  assign artik_yil     = artik_mi(yil_q[1:0]);
  assign mesgul        = mesgul_q;
  assign bitti         = bitti_q;
  assign hata          = hata_q;
  assign gun_bitti     = gun_bitti_q;
  assign yil_tasma     = yil_tasma_q;

endmodule
